branch_recovery_ctrl: RTL and testbench
=======================================

Name: branch_recovery_ctrl

Overview:
- Sits between the execute-stage branch units and the checkpointer.
- Each cycle it turns resolved branches into checkpoint validations. On a misprediction it picks the oldest mispredicting branch and issues the recall handshake to the checkpointer.
- It captures the recalled checkpoint line, unpacks it into free-list, active-list, RMT and BBL restore fields, and holds them with a frontend redirect until the rename stage acknowledges the restore.

Parameters:
- NUM_CHECKPOINTS, `NUM_CHECKPOINTS, checkpoint slots; power of two.
- NUM_RESOLVE, `NUM_BRANCHES_RESOLVED, branch resolution lanes per cycle.
- AL_SIZE, `AL_SIZE, active-list entries; A = $clog2(AL_SIZE).
- LINE_SIZE, 3*A+660, checkpoint line width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- br_valid  in  [NUM_RESOLVE] x1  lane resolved a branch this cycle
- br_mispredict  in  [NUM_RESOLVE] x1  lane's branch mispredicted
- br_ckpt_id  in  [NUM_RESOLVE] x$clog2(NUM_CHECKPOINTS)  checkpoint owned by lane's branch
- br_target  in  [NUM_RESOLVE] x64  correct PC for lane's branch
- oldest_ckpt_id  in  $clog2(NUM_CHECKPOINTS)  oldest live checkpoint, used for age ordering
- recalled_data  in  LINE_SIZE  checkpoint line; asynchronous read, valid in the same cycle as recall_id
- restore_ack  in  1  rename stage has consumed the restore
- validate  out  [NUM_RESOLVE] x1  registered checkpoint validation
- validated_id  out  [NUM_RESOLVE] x$clog2(NUM_CHECKPOINTS)  id being validated
- recall_checkpoint  out  1  recall strobe
- recall_id  out  $clog2(NUM_CHECKPOINTS)  checkpoint to recall
- flush_frontend  out  1  one-cycle flush pulse
- redirect_pc  out  64  correct fetch PC, valid with flush_frontend
- restore_valid  out  1  restore fields are valid
- restore_free_list  out  64x6  from line bits [i*6+:6]
- restore_fl_size  out  7  from line bits [390:384]
- restore_fl_front  out  6  from line bits [396:391]
- restore_fl_back  out  6  from line bits [402:397]
- restore_al_front  out  A  from line bits [403+:A]
- restore_rmt  out  32x6  from line bits [T+i*6+:6], T = 3A+404
- restore_bbl  out  64  from line bits [T+192+:64]
- recovery_busy  out  1  asserted when state != IDLE

Behaviour:
- Reset: state IDLE. Every output is 0, including validate, recall_checkpoint, flush_frontend, restore_valid, recovery_busy and all data fields. Reset asserted mid-recovery aborts the recovery immediately.
- Age of a checkpoint id = (id - oldest_ckpt_id) mod NUM_CHECKPOINTS, computed with unsigned wrap in $clog2(NUM_CHECKPOINTS) bits. Smaller age means older.
- Candidate mispredict: the lane with br_valid && br_mispredict and the minimum age. On equal age, the lowest lane index wins.
- Validation: validate[i] and validated_id[i] are registered with one-cycle latency, from br_valid[i] && !br_mispredict[i].
  - A lane is suppressed if, in the same cycle, a mispredict is accepted or in progress whose age is less than or equal to the lane's age (that branch is squashed).
  - An older correct branch still validates.
- FSM:
  - IDLE: when a candidate exists, latch target_id and target_pc, then go to RECALL.
  - RECALL (exactly 1 cycle): drive recall_checkpoint=1, recall_id=target_id, flush_frontend=1, redirect_pc=target_pc. Register recalled_data into the restore fields at the clock edge, then go to RESTORE.
  - RESTORE: hold restore_valid=1 and the restore fields stable. When restore_ack=1, go to IDLE with restore_valid=0 on the next cycle.
- Preemption: in RECALL or RESTORE, a candidate strictly older than target_id replaces target_id/target_pc and the FSM goes to RECALL next cycle. restore_valid drops during that cycle even if restore_ack is asserted simultaneously.
- Dropping: candidates younger than or equal in age to target_id are dropped and never recalled.
- In IDLE, a candidate is accepted in the same cycle that restore_ack is ignored; restore_ack has no effect outside RESTORE.
- recovery_busy = (state != IDLE) and is purely combinational.
- Wrap-around: age ordering must be correct when ids wrap, e.g. with oldest=6 and N=8, id 7 is older than id 1.

Test Plan:
- Single mispredict: N=8, A=6, lane0 mispredict, id=3, target 0x1000, oldest=0 -> recall_id=3, flush and redirect_pc=0x1000 for 1 cycle. Next cycle restore_valid=1 with restore_fl_size equal to recalled_data[390:384]. restore_ack -> IDLE one cycle later.
- Field unpack: recalled_data with RMT[5]=0x2A and bbl=0xDEADBEEF_00000001 -> restore_rmt[5]=0x2A, restore_bbl matches, restore_al_front = bits [408:403].
- Dual mispredict with wrap: oldest=6, lane0 id=1, lane1 id=7 -> recall_id=7.
- Preemption: in RESTORE for id=4 (oldest=2), a mispredict on id=3 arrives -> RECALL id=3 next cycle, restore_valid=0 for that cycle. A later mispredict on id=5 is ignored.
- Validation squash: in RESTORE for id=2 (oldest=0), correct branches on id=1 and id=5 -> validate only id=1, one cycle later.
- Reset mid-recovery: assert reset in RESTORE -> all outputs 0 next cycle, state IDLE, no further recall.

Source files
------------

// File: rtl/branch_recovery_ctrl.sv
// Branch recovery controller: validates correct branches, recalls the oldest mispredicted checkpoint, holds restore fields.
// Latency: validate 1 cycle after resolve; recall 1 cycle after mispredict; restore fields valid the cycle after recall.
// Backpressure: restore held until restore_ack; an older mispredict preempts, younger ones are dropped.
module branch_recovery_ctrl #(
    parameter int NUM_CHECKPOINTS = 8,
    parameter int NUM_RESOLVE     = 2,
    parameter int AL_SIZE         = 64,
    parameter int LINE_SIZE       = 3 * $clog2(AL_SIZE) + 660,
    localparam int A              = $clog2(AL_SIZE),
    localparam int CW             = $clog2(NUM_CHECKPOINTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RESOLVE-1:0] br_valid,
    input  logic [NUM_RESOLVE-1:0] br_mispredict,
    input  logic [CW-1:0]          br_ckpt_id [NUM_RESOLVE],
    input  logic [63:0]            br_target [NUM_RESOLVE],
    input  logic [CW-1:0]          oldest_ckpt_id,
    input  logic [LINE_SIZE-1:0]   recalled_data,
    input  logic                   restore_ack,
    output logic [NUM_RESOLVE-1:0] validate,
    output logic [CW-1:0]          validated_id [NUM_RESOLVE],
    output logic                   recall_checkpoint,
    output logic [CW-1:0]          recall_id,
    output logic                   flush_frontend,
    output logic [63:0]            redirect_pc,
    output logic                   restore_valid,
    output logic [5:0]             restore_free_list [64],
    output logic [6:0]             restore_fl_size,
    output logic [5:0]             restore_fl_front,
    output logic [5:0]             restore_fl_back,
    output logic [A-1:0]           restore_al_front,
    output logic [5:0]             restore_rmt [32],
    output logic [63:0]            restore_bbl,
    output logic                   recovery_busy
);

    // Base bit of the RMT section inside the checkpoint line.
    localparam int T = 3 * A + 404;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECALL,
        S_RESTORE
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            tgt_id_q, tgt_id_d;
    logic [63:0]              tgt_pc_q, tgt_pc_d;
    logic [LINE_SIZE-1:0]     line_q, line_d;
    logic [NUM_RESOLVE-1:0]   validate_q, validate_d;
    logic [CW-1:0]            vid_q [NUM_RESOLVE];
    logic [CW-1:0]            vid_d [NUM_RESOLVE];

    logic [CW-1:0]            lane_age [NUM_RESOLVE];
    logic                     cand_vld;
    logic [CW-1:0]            cand_age;
    logic [CW-1:0]            cand_id;
    logic [63:0]              cand_pc;
    logic [CW-1:0]            tgt_age;
    logic                     busy;
    logic                     accept;
    logic                     sq_vld;
    logic [CW-1:0]            sq_age;

    // Age of each lane's checkpoint relative to the oldest live one (modular wrap).
    always_comb begin
        for (int i = 0; i < NUM_RESOLVE; i++) begin
            lane_age[i] = br_ckpt_id[i] - oldest_ckpt_id;
        end
    end

    // Oldest mispredicting lane this cycle; ties go to the lowest lane index.
    always_comb begin
        cand_vld = 1'b0;
        cand_age = '0;
        cand_id  = '0;
        cand_pc  = '0;
        for (int i = 0; i < NUM_RESOLVE; i++) begin
            if (br_valid[i] && br_mispredict[i] && (!cand_vld || lane_age[i] < cand_age)) begin
                cand_vld = 1'b1;
                cand_age = lane_age[i];
                cand_id  = br_ckpt_id[i];
                cand_pc  = br_target[i];
            end
        end
    end

    assign tgt_age = tgt_id_q - oldest_ckpt_id;
    assign busy    = (state_q != S_IDLE);
    // While recovering, only a strictly older mispredict may take over.
    assign accept  = cand_vld && (!busy || cand_age < tgt_age);

    // Recovery FSM: next state, target latch and checkpoint line capture.
    always_comb begin
        state_d  = state_q;
        tgt_id_d = tgt_id_q;
        tgt_pc_d = tgt_pc_q;
        line_d   = line_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tgt_id_d = cand_id;
                    tgt_pc_d = cand_pc;
                    state_d  = S_RECALL;
                end
            end
            S_RECALL: begin
                if (accept) begin
                    tgt_id_d = cand_id;
                    tgt_pc_d = cand_pc;
                    state_d  = S_RECALL;
                end else begin
                    line_d  = recalled_data;
                    state_d = S_RESTORE;
                end
            end
            S_RESTORE: begin
                if (accept) begin
                    tgt_id_d = cand_id;
                    tgt_pc_d = cand_pc;
                    state_d  = S_RECALL;
                end else if (restore_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Correct branches validate unless a same-age-or-older mispredict squashes them.
    always_comb begin
        sq_vld = accept || busy;
        sq_age = accept ? cand_age : tgt_age;
        for (int i = 0; i < NUM_RESOLVE; i++) begin
            validate_d[i] = br_valid[i] && !br_mispredict[i] && !(sq_vld && lane_age[i] >= sq_age);
            vid_d[i]      = validate_d[i] ? br_ckpt_id[i] : '0;
        end
    end

    // State and data registers; reset aborts any recovery in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tgt_id_q   <= '0;
            tgt_pc_q   <= '0;
            line_q     <= '0;
            validate_q <= '0;
            for (int i = 0; i < NUM_RESOLVE; i++) begin
                vid_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tgt_id_q   <= tgt_id_d;
            tgt_pc_q   <= tgt_pc_d;
            line_q     <= line_d;
            validate_q <= validate_d;
            for (int i = 0; i < NUM_RESOLVE; i++) begin
                vid_q[i] <= vid_d[i];
            end
        end
    end

    assign validate          = validate_q;
    assign validated_id      = vid_q;
    assign recall_checkpoint = (state_q == S_RECALL);
    assign flush_frontend    = (state_q == S_RECALL);
    assign recall_id         = (state_q == S_RECALL) ? tgt_id_q : '0;
    assign redirect_pc       = (state_q == S_RECALL) ? tgt_pc_q : '0;
    assign restore_valid     = (state_q == S_RESTORE);
    assign recovery_busy     = busy;

    // Unpack the captured checkpoint line into the rename restore fields.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            restore_free_list[i] = line_q[i*6 +: 6];
        end
        for (int i = 0; i < 32; i++) begin
            restore_rmt[i] = line_q[T + i*6 +: 6];
        end
    end

    assign restore_fl_size  = line_q[390:384];
    assign restore_fl_front = line_q[396:391];
    assign restore_fl_back  = line_q[402:397];
    assign restore_al_front = line_q[403 +: A];
    assign restore_bbl      = line_q[T + 192 +: 64];

    // Gap between the active-list front and the RMT carries nothing for rename.
    logic unused_line_bits;
    assign unused_line_bits = ^{line_q[T-1:403+A], line_q[LINE_SIZE-1:T+256]};

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed table-driven bench for branch_recovery_ctrl plus multi-cycle corner sequences.
// Latency: expectations are sampled 1 ns after each rising edge.
// Backpressure: restore_ack driven directly from the vector table.
module tb_branch_recovery_ctrl;

    localparam int N  = 8;
    localparam int R  = 2;
    localparam int AL = 64;
    localparam int A  = 6;
    localparam int LS = 3 * A + 660;
    localparam int T  = 3 * A + 404;

    logic          clk;
    logic          reset;
    logic [R-1:0]  br_valid;
    logic [R-1:0]  br_mispredict;
    logic [2:0]    br_ckpt_id [R];
    logic [63:0]   br_target [R];
    logic [2:0]    oldest_ckpt_id;
    logic [LS-1:0] recalled_data;
    logic          restore_ack;
    logic [R-1:0]  validate;
    logic [2:0]    validated_id [R];
    logic          recall_checkpoint;
    logic [2:0]    recall_id;
    logic          flush_frontend;
    logic [63:0]   redirect_pc;
    logic          restore_valid;
    logic [5:0]    restore_free_list [64];
    logic [6:0]    restore_fl_size;
    logic [5:0]    restore_fl_front;
    logic [5:0]    restore_fl_back;
    logic [A-1:0]  restore_al_front;
    logic [5:0]    restore_rmt [32];
    logic [63:0]   restore_bbl;
    logic          recovery_busy;

    branch_recovery_ctrl #(
        .NUM_CHECKPOINTS(N),
        .NUM_RESOLVE    (R),
        .AL_SIZE        (AL),
        .LINE_SIZE      (LS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .br_valid         (br_valid),
        .br_mispredict    (br_mispredict),
        .br_ckpt_id       (br_ckpt_id),
        .br_target        (br_target),
        .oldest_ckpt_id   (oldest_ckpt_id),
        .recalled_data    (recalled_data),
        .restore_ack      (restore_ack),
        .validate         (validate),
        .validated_id     (validated_id),
        .recall_checkpoint(recall_checkpoint),
        .recall_id        (recall_id),
        .flush_frontend   (flush_frontend),
        .redirect_pc      (redirect_pc),
        .restore_valid    (restore_valid),
        .restore_free_list(restore_free_list),
        .restore_fl_size  (restore_fl_size),
        .restore_fl_front (restore_fl_front),
        .restore_fl_back  (restore_fl_back),
        .restore_al_front (restore_al_front),
        .restore_rmt      (restore_rmt),
        .restore_bbl      (restore_bbl),
        .recovery_busy    (recovery_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checkpointer model: asynchronous read of the line selected by recall_id.
    logic [LS-1:0] mem [N];
    assign recalled_data = mem[recall_id];

    function automatic logic [LS-1:0] mk_line(input int k);
        logic [LS-1:0] l;
        l = '0;
        for (int i = 0; i < 64; i++) l[i*6 +: 6] = 6'((i ^ k) & 63);
        l[390:384] = 7'(k * 9 + 5);
        l[396:391] = 6'(k + 1);
        l[402:397] = 6'(k + 2);
        l[403 +: A] = 6'(k * 3);
        l[T-1:403+A] = '1;
        for (int i = 0; i < 32; i++) l[T + i*6 +: 6] = 6'(i + k);
        l[T + 5*6 +: 6] = 6'h2A;
        l[T + 192 +: 64] = 64'hDEADBEEF_00000001 + 64'(k);
        return l;
    endfunction

    typedef struct packed {
        logic        rst;
        logic [1:0]  v;
        logic [1:0]  m;
        logic [2:0]  id0;
        logic [2:0]  id1;
        logic [2:0]  old;
        logic [15:0] t0;
        logic [15:0] t1;
        logic        ack;
        logic [1:0]  e_val;
        logic [2:0]  e_vid0;
        logic [2:0]  e_vid1;
        logic        e_rec;
        logic [2:0]  e_rid;
        logic [15:0] e_pc;
        logic        e_rv;
        logic [6:0]  e_fls;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic [1:0] v, input logic [1:0] m,
        input logic [2:0] id0, input logic [2:0] id1, input logic [2:0] old,
        input logic [15:0] t0, input logic [15:0] t1, input logic ack,
        input logic [1:0] e_val, input logic [2:0] e_vid0, input logic [2:0] e_vid1,
        input logic e_rec, input logic [2:0] e_rid, input logic [15:0] e_pc,
        input logic e_rv, input logic [6:0] e_fls, input logic e_busy);
        vec_t r;
        r.rst = rst; r.v = v; r.m = m; r.id0 = id0; r.id1 = id1; r.old = old;
        r.t0 = t0; r.t1 = t1; r.ack = ack; r.e_val = e_val; r.e_vid0 = e_vid0;
        r.e_vid1 = e_vid1; r.e_rec = e_rec; r.e_rid = e_rid; r.e_pc = e_pc;
        r.e_rv = e_rv; r.e_fls = e_fls; r.e_busy = e_busy;
        return r;
    endfunction

    int checks;
    int failures;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] m,
                         input logic [2:0] id0, input logic [2:0] id1, input logic [2:0] old,
                         input logic [63:0] t0, input logic [63:0] t1, input logic ack);
        reset          = rst;
        br_valid       = v;
        br_mispredict  = m;
        br_ckpt_id[0]  = id0;
        br_ckpt_id[1]  = id1;
        oldest_ckpt_id = old;
        br_target[0]   = t0;
        br_target[1]   = t1;
        restore_ack    = ack;
    endtask

    vec_t vt [28];

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < N; k++) mem[k] = mk_line(k);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //        rst v  m  id0 id1 old t0       t1       ack | val vid0 vid1 rec rid pc       rv fls busy
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[2]  = mk(0, 1, 1, 3, 0, 0, 16'h1000, 16'h0,    0,   0, 0, 0, 1, 3, 16'h1000, 0, 0,  1);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 32, 1);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 32, 1);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    1,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    1,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[7]  = mk(0, 3, 3, 1, 7, 6, 16'h2000, 16'h3000, 0,   0, 0, 0, 1, 7, 16'h3000, 0, 0,  1);
        vt[8]  = mk(0, 0, 0, 0, 0, 6, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 68, 1);
        vt[9]  = mk(0, 0, 0, 0, 0, 6, 16'h0,    16'h0,    1,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[10] = mk(0, 1, 1, 4, 0, 2, 16'h4000, 16'h0,    0,   0, 0, 0, 1, 4, 16'h4000, 0, 0,  1);
        vt[11] = mk(0, 0, 0, 0, 0, 2, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 41, 1);
        vt[12] = mk(0, 1, 1, 3, 0, 2, 16'h5000, 16'h0,    1,   0, 0, 0, 1, 3, 16'h5000, 0, 0,  1);
        vt[13] = mk(0, 0, 0, 0, 0, 2, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 32, 1);
        vt[14] = mk(0, 1, 1, 5, 0, 2, 16'h6000, 16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 32, 1);
        vt[15] = mk(0, 0, 0, 0, 0, 2, 16'h0,    16'h0,    1,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[16] = mk(0, 1, 1, 2, 0, 0, 16'h7000, 16'h0,    0,   0, 0, 0, 1, 2, 16'h7000, 0, 0,  1);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 23, 1);
        vt[18] = mk(0, 3, 0, 1, 5, 0, 16'h0,    16'h0,    0,   1, 1, 0, 0, 0, 16'h0,    1, 23, 1);
        vt[19] = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    1,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[20] = mk(0, 3, 1, 3, 3, 0, 16'h8000, 16'h0,    0,   0, 0, 0, 1, 3, 16'h8000, 0, 0,  1);
        vt[21] = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 32, 1);
        vt[22] = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    1,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[23] = mk(0, 3, 3, 5, 5, 0, 16'h9000, 16'hA000, 0,   0, 0, 0, 1, 5, 16'h9000, 0, 0,  1);
        vt[24] = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    1, 50, 1);
        vt[25] = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    1,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);
        vt[26] = mk(0, 3, 0, 6, 7, 0, 16'h0,    16'h0,    0,   3, 6, 7, 0, 0, 16'h0,    0, 0,  0);
        vt[27] = mk(0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0,   0, 0, 0, 0, 0, 16'h0,    0, 0,  0);

        #2;
        for (int i = 0; i < 28; i++) begin
            drive(vt[i].rst, vt[i].v, vt[i].m, vt[i].id0, vt[i].id1, vt[i].old,
                  64'(vt[i].t0), 64'(vt[i].t1), vt[i].ack);
            step();
            chk($sformatf("r%0d.validate", i), 64'(validate), 64'(vt[i].e_val));
            if (vt[i].e_val[0]) chk($sformatf("r%0d.vid0", i), 64'(validated_id[0]), 64'(vt[i].e_vid0));
            if (vt[i].e_val[1]) chk($sformatf("r%0d.vid1", i), 64'(validated_id[1]), 64'(vt[i].e_vid1));
            chk($sformatf("r%0d.recall", i), 64'(recall_checkpoint), 64'(vt[i].e_rec));
            chk($sformatf("r%0d.flush", i), 64'(flush_frontend), 64'(vt[i].e_rec));
            if (vt[i].e_rec || vt[i].rst) begin
                chk($sformatf("r%0d.recall_id", i), 64'(recall_id), 64'(vt[i].e_rid));
                chk($sformatf("r%0d.redirect_pc", i), redirect_pc, 64'(vt[i].e_pc));
            end
            chk($sformatf("r%0d.restore_valid", i), 64'(restore_valid), 64'(vt[i].e_rv));
            if (vt[i].e_rv || vt[i].rst)
                chk($sformatf("r%0d.fl_size", i), 64'(restore_fl_size), 64'(vt[i].e_fls));
            chk($sformatf("r%0d.busy", i), 64'(recovery_busy), 64'(vt[i].e_busy));
        end

        // Field unpack of checkpoint 3.
        drive(0, 1, 1, 3, 0, 0, 64'h1000, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("unpack.rv", 64'(restore_valid), 64'd1);
        chk("unpack.rmt5", 64'(restore_rmt[5]), 64'h2A);
        chk("unpack.rmt0", 64'(restore_rmt[0]), 64'd3);
        chk("unpack.rmt31", 64'(restore_rmt[31]), 64'd34);
        chk("unpack.bbl", restore_bbl, 64'hDEADBEEF_00000004);
        chk("unpack.al_front", 64'(restore_al_front), 64'd9);
        chk("unpack.fl10", 64'(restore_free_list[10]), 64'd9);
        chk("unpack.fl_front", 64'(restore_fl_front), 64'd4);
        chk("unpack.fl_back", 64'(restore_fl_back), 64'd5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("unpack.idle", 64'(recovery_busy), 64'd0);

        // Reset while restoring checkpoint 6.
        drive(0, 1, 1, 6, 0, 0, 64'hBEEF, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rstmid.rv_before", 64'(restore_valid), 64'd1);
        chk("rstmid.fls_before", 64'(restore_fl_size), 64'd59);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rstmid.busy", 64'(recovery_busy), 64'd0);
        chk("rstmid.rv", 64'(restore_valid), 64'd0);
        chk("rstmid.recall", 64'(recall_checkpoint), 64'd0);
        chk("rstmid.flush", 64'(flush_frontend), 64'd0);
        chk("rstmid.pc", redirect_pc, 64'd0);
        chk("rstmid.fls", 64'(restore_fl_size), 64'd0);
        chk("rstmid.bbl", restore_bbl, 64'd0);
        chk("rstmid.validate", 64'(validate), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rstmid.after%0d.recall", c), 64'(recall_checkpoint), 64'd0);
            chk($sformatf("rstmid.after%0d.busy", c), 64'(recovery_busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
